// File: rtl/pkmn_pkg.sv
// Shared types and constants for the party XP award block.
package pkmn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        LVLUP = 2'd2,
        DONE  = 2'd3
    } xp_state_t;

    localparam logic [7:0] XP_MAX      = 8'd255;
    localparam int         MAX_LVL     = 15;
    localparam int         N_SLOTS_DEF = 4;

    typedef logic [$clog2(N_SLOTS_DEF)-1:0] slot_t;

endpackage

// File: rtl/pkmn_xp_award_if.sv
// Award / load / read bus between the battle FSM, the HUD and pkmn_xp_award.
// Award handshake: a request transfers on a clock edge where award_valid and
// award_ready are both high; award_valid with award_ready low is not captured.
interface pkmn_xp_award_if
    import pkmn_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int XP_W    = 8,
    parameter int LVL_W   = 4
);
    localparam int SLOT_W = $clog2(N_SLOTS);

    logic              award_valid;
    logic              award_ready;
    logic [SLOT_W-1:0] award_slot;
    logic [XP_W-1:0]   award_xp;
    logic              ld_en;
    logic [SLOT_W-1:0] ld_slot;
    logic [XP_W-1:0]   ld_xp;
    logic [LVL_W-1:0]  ld_lvl;
    logic              tick;
    logic [SLOT_W-1:0] rd_slot;
    logic [XP_W-1:0]   rd_xp;
    logic [LVL_W-1:0]  rd_lvl;
    logic              busy;
    logic              level_up;
    logic              done;
    xp_state_t         dbg_state;

    modport master (
        output award_valid, award_slot, award_xp,
        output ld_en, ld_slot, ld_xp, ld_lvl,
        output tick, rd_slot,
        input  award_ready, rd_xp, rd_lvl, busy, level_up, done, dbg_state
    );

    modport slave (
        input  award_valid, award_slot, award_xp,
        input  ld_en, ld_slot, ld_xp, ld_lvl,
        input  tick, rd_slot,
        output award_ready, rd_xp, rd_lvl, busy, level_up, done, dbg_state
    );

endinterface

// File: rtl/xp_slot_regfile.sv
// Party XP/level storage: one write port, one registered read port, plus a
// combinational peek of the slot being animated so the FSM sees live values.
module xp_slot_regfile #(
    parameter int N_SLOTS  = 4,
    parameter int XP_W     = 8,
    parameter int LVL_W    = 4,
    parameter int INIT_LVL = 5,
    localparam int SLOT_W  = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [SLOT_W-1:0] waddr_i,
    input  logic [XP_W-1:0]   wxp_i,
    input  logic [LVL_W-1:0]  wlvl_i,
    input  logic [SLOT_W-1:0] raddr_i,
    output logic [XP_W-1:0]   rxp_o,
    output logic [LVL_W-1:0]  rlvl_o,
    input  logic [SLOT_W-1:0] paddr_i,
    output logic [XP_W-1:0]   pxp_o,
    output logic [LVL_W-1:0]  plvl_o
);
    logic [XP_W-1:0]  xp_q  [N_SLOTS];
    logic [LVL_W-1:0] lvl_q [N_SLOTS];
    logic [XP_W-1:0]  rxp_q;
    logic [LVL_W-1:0] rlvl_q;

    // The read register samples before the write lands, so a same-cycle
    // write shows up on the read port one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                xp_q[i]  <= '0;
                lvl_q[i] <= LVL_W'(INIT_LVL);
            end
            rxp_q  <= '0;
            rlvl_q <= LVL_W'(INIT_LVL);
        end else begin
            if (we_i) begin
                xp_q[waddr_i]  <= wxp_i;
                lvl_q[waddr_i] <= wlvl_i;
            end
            rxp_q  <= xp_q[raddr_i];
            rlvl_q <= lvl_q[raddr_i];
        end
    end

    assign rxp_o  = rxp_q;
    assign rlvl_o = rlvl_q;
    assign pxp_o  = xp_q[paddr_i];
    assign plvl_o = lvl_q[paddr_i];

endmodule

// File: rtl/pkmn_xp_award.sv
// Animates a per-battle XP award into one party slot, one point per frame tick,
// with a level-up pause on each bar wrap. Owns the party XP/level storage.
module pkmn_xp_award
    import pkmn_pkg::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int XP_W        = 8,
    parameter int LVL_W       = 4,
    parameter int MAX_LVL     = pkmn_pkg::MAX_LVL,
    parameter int INIT_LVL    = 5,
    parameter int PAUSE_TICKS = 30
) (
    input  logic          Clk,
    input  logic          Reset_n,
    pkmn_xp_award_if.slave bus
);
    localparam int SLOT_W  = $clog2(N_SLOTS);
    localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);
    localparam logic [XP_W-1:0]    XP_TOP     = (XP_W == 8) ? XP_W'(XP_MAX) : '1;
    localparam logic [LVL_W-1:0]   LVL_TOP    = LVL_W'(MAX_LVL);
    localparam logic [LVL_W:0]     LVL_TOP_X  = (LVL_W + 1)'(MAX_LVL);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);

    xp_state_t          state_q, state_d;
    logic [XP_W-1:0]    remaining_q, remaining_d;
    logic [SLOT_W-1:0]  cur_slot_q, cur_slot_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic               level_up_q, level_up_d;

    logic              we;
    logic [SLOT_W-1:0] waddr;
    logic [XP_W-1:0]   wxp;
    logic [LVL_W-1:0]  wlvl;
    logic [XP_W-1:0]   cur_xp;
    logic [LVL_W-1:0]  cur_lvl;
    logic [LVL_W:0]    ld_lvl_x;

    xp_slot_regfile #(
        .N_SLOTS  (N_SLOTS),
        .XP_W     (XP_W),
        .LVL_W    (LVL_W),
        .INIT_LVL (INIT_LVL)
    ) u_regfile (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wxp_i   (wxp),
        .wlvl_i  (wlvl),
        .raddr_i (bus.rd_slot),
        .rxp_o   (bus.rd_xp),
        .rlvl_o  (bus.rd_lvl),
        .paddr_i (cur_slot_q),
        .pxp_o   (cur_xp),
        .plvl_o  (cur_lvl)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cur_slot_q  <= '0;
            pause_q     <= '0;
            level_up_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_slot_q  <= cur_slot_d;
            pause_q     <= pause_d;
            level_up_q  <= level_up_d;
        end
    end

    // Widened by one bit so the clamp stays meaningful when MAX_LVL fills LVL_W.
    assign ld_lvl_x = {1'b0, bus.ld_lvl};

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_slot_d  = cur_slot_q;
        pause_d     = pause_q;
        level_up_d  = 1'b0;
        we          = 1'b0;
        waddr       = cur_slot_q;
        wxp         = cur_xp;
        wlvl        = cur_lvl;

        case (state_q)
            IDLE: begin
                if (bus.award_valid) begin
                    cur_slot_d  = bus.award_slot;
                    remaining_d = bus.award_xp;
                    state_d     = FILL;
                end else if (bus.ld_en) begin
                    we    = 1'b1;
                    waddr = bus.ld_slot;
                    wxp   = bus.ld_xp;
                    wlvl  = (ld_lvl_x > LVL_TOP_X) ? LVL_TOP : bus.ld_lvl;
                end
            end
            FILL: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else if (cur_lvl == LVL_TOP && cur_xp == XP_TOP) begin
                    // Capped slot: whatever is left of the award is thrown away.
                    remaining_d = '0;
                    state_d     = DONE;
                end else if (bus.tick) begin
                    remaining_d = remaining_q - 1'b1;
                    we          = 1'b1;
                    if (cur_xp == XP_TOP) begin
                        wxp        = '0;
                        wlvl       = cur_lvl + 1'b1;
                        level_up_d = 1'b1;
                        pause_d    = '0;
                        state_d    = LVLUP;
                    end else begin
                        wxp = cur_xp + 1'b1;
                    end
                end
            end
            LVLUP: begin
                if (bus.tick) begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_d = '0;
                        state_d = FILL;
                    end else begin
                        pause_d = pause_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.award_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.level_up    = level_up_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pkmn_xp_award.sv
// Scoreboard bench for pkmn_xp_award: directed scenarios then randomized awards,
// checked against an arithmetic model of total XP (level*256 + bar).
module tb_pkmn_xp_award;
    localparam int TB_MAX_LVL  = 15;
    localparam int TB_INIT_LVL = 5;
    localparam int TB_PAUSE    = 30;
    localparam int TB_CAP      = TB_MAX_LVL * 256 + 255;
    localparam logic [15:0] NO_LAT = 16'hFFFF;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   tick_mode;
    int   acc_cyc;
    int   lu_cnt;
    int   m_xp  [4];
    int   m_lvl [4];

    // {latency[15:0], level_ups[3:0], level[3:0], xp[7:0]}
    logic [31:0] exp_q[$];

    pkmn_xp_award_if #(.N_SLOTS(4), .XP_W(8), .LVL_W(4)) bus ();

    pkmn_xp_award #(
        .N_SLOTS     (4),
        .XP_W        (8),
        .LVL_W       (4),
        .MAX_LVL     (TB_MAX_LVL),
        .INIT_LVL    (TB_INIT_LVL),
        .PAUSE_TICKS (TB_PAUSE)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_award(input int s, input int a, input bit timed);
        int old_t, new_t, lu, lat;
        old_t = m_lvl[s] * 256 + m_xp[s];
        new_t = old_t + a;
        if (new_t > TB_CAP) new_t = TB_CAP;
        lu  = new_t / 256 - m_lvl[s];
        lat = timed ? (new_t - old_t) + 2 + TB_PAUSE * lu : int'(NO_LAT);
        m_lvl[s] = new_t / 256;
        m_xp[s]  = new_t % 256;
        return {16'(lat), 4'(lu), 4'(m_lvl[s]), 8'(m_xp[s])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_xp[i]  = 0;
            m_lvl[i] = TB_INIT_LVL;
        end
    endtask

    // ---------------- tick generator ----------------
    initial begin
        forever begin
            @(negedge clk);
            case (tick_mode)
                1:       bus.tick = 1'b1;
                2:       bus.tick = 1'($urandom_range(0, 1));
                default: bus.tick = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus.award_valid && bus.award_ready) begin
                    acc_cyc = cyc;
                    lu_cnt  = 0;
                end
                if (bus.level_up) lu_cnt++;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("final_xp", int'(bus.rd_xp), int'(e[7:0]));
                        chk("final_lvl", int'(bus.rd_lvl), int'(e[11:8]));
                        chk("level_up_count", lu_cnt, int'(e[15:12]));
                        if (e[31:16] != NO_LAT)
                            chk("done_latency", cyc - acc_cyc, int'(e[31:16]));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input int s, input int xp, input int lvl);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_slot = 2'(s);
        bus.ld_xp   = 8'(xp);
        bus.ld_lvl  = 4'(lvl);
        @(negedge clk);
        bus.ld_en = 1'b0;
        m_xp[s]  = xp;
        m_lvl[s] = (lvl > TB_MAX_LVL) ? TB_MAX_LVL : lvl;
    endtask

    task automatic do_award(input int s, input int a, input bit timed);
        int waited;
        exp_q.push_back(model_award(s, a, timed));
        @(negedge clk);
        bus.award_valid = 1'b1;
        bus.award_slot  = 2'(s);
        bus.award_xp    = 8'(a);
        waited = 0;
        while (!bus.award_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.award_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        bus.award_valid = 1'b0;
        bus.rd_slot     = 2'(s);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic check_slot(input int s);
        @(negedge clk);
        bus.rd_slot = 2'(s);
        @(negedge clk);
        chk($sformatf("slot%0d_xp", s), int'(bus.rd_xp), m_xp[s]);
        chk($sformatf("slot%0d_lvl", s), int'(bus.rd_lvl), m_lvl[s]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, a, n;
        bit timed;
        n_vec = 0;
        n_err = 0;
        tick_mode = 0;
        acc_cyc = 0;
        lu_cnt = 0;
        rst_n = 1'b0;
        bus.award_valid = 1'b0;
        bus.award_slot  = '0;
        bus.award_xp    = '0;
        bus.ld_en       = 1'b0;
        bus.ld_slot     = '0;
        bus.ld_xp       = '0;
        bus.ld_lvl      = '0;
        bus.tick        = 1'b0;
        bus.rd_slot     = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.award_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_level_up", int'(bus.level_up), 0);
        chk("rst_rd_xp", int'(bus.rd_xp), 0);
        chk("rst_rd_lvl", int'(bus.rd_lvl), TB_INIT_LVL);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) check_slot(i);

        // 1: plain fill, no wrap
        tick_mode = 1;
        do_award(0, 75, 1'b1);
        wait_idle();
        check_slot(0);

        // 2: one wrap with a level-up pause
        do_award(0, 200, 1'b1);
        wait_idle();
        check_slot(0);

        // 3: capped slot discards the leftover
        do_load(2, 250, 15);
        do_award(2, 20, 1'b1);
        wait_idle();
        check_slot(2);

        // 4: request while busy waits for the first award to finish
        do_award(1, 100, 1'b1);
        @(negedge clk);
        chk("busy_ready_low", int'(bus.award_ready), 0);
        chk("busy_high", int'(bus.busy), 1);
        do_award(3, 50, 1'b1);
        wait_idle();
        check_slot(1);
        check_slot(3);

        // 5: zero award
        do_award(1, 0, 1'b1);
        chk("zero_busy_fill", int'(bus.busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("zero_idle_again", int'(bus.busy), 0);
        check_slot(1);

        // 6: reset in the middle of a fill
        do_load(0, 0, 5);
        do_award(0, 100, 1'b1);
        n = 0;
        while (bus.rd_xp != 8'd40 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_xp40", int'(bus.rd_xp), 40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(bus.award_ready), 1);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_level_up", int'(bus.level_up), 0);
        chk("midrst_rd_xp", int'(bus.rd_xp), 0);
        chk("midrst_rd_lvl", int'(bus.rd_lvl), TB_INIT_LVL);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_tick_busy", int'(bus.busy), 0);
        end
        check_slot(0);
        check_slot(2);

        // randomized awards and loads
        for (int it = 0; it < 24; it++) begin
            s = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                do_load(s, $urandom_range(0, 255), $urandom_range(0, 15));
            timed = 1'($urandom_range(0, 1));
            tick_mode = timed ? 1 : 2;
            a = $urandom_range(0, 255);
            do_award(s, a, timed);
            wait_idle();
            if ($urandom_range(0, 1) == 1) check_slot($urandom_range(0, 3));
        end

        tick_mode = 0;
        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) check_slot(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
